// File: rtl/toggle_rx_pkg.sv
// Shared definitions for the toggle receiver: FSM encodings and parameter defaults.
// Consumers: toggle_rx and sync_chain.
package toggle_rx_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PULSE = 2'd1,
        HOLD  = 2'd2
    } state_e;

    localparam int TOGGLE_RX_SYNC_STAGES_DEF = 2;
    localparam int TOGGLE_RX_HOLDOFF_DEF     = 3;
    localparam int TOGGLE_RX_CNT_W_DEF       = 8;

endpackage

// File: rtl/toggle_rx_sync_chain.sv
// Multi-flop synchronizer for the asynchronous toggle line.
// Under Clear every stage loads init so the current line level is not seen as an edge.
module sync_chain
    import toggle_rx_pkg::*;
#(
    parameter int STAGES = TOGGLE_RX_SYNC_STAGES_DEF
) (
    input  logic Clock,
    input  logic Clear,
    input  logic d,
    input  logic init,
    output logic q
);

    logic [STAGES-1:0] chain_q;

    // Shift register; stage 0 samples the raw asynchronous input.
    always_ff @(posedge Clock) begin
        if (Clear) begin
            chain_q <= {STAGES{init}};
        end else begin
            chain_q <= {chain_q[STAGES-2:0], d};
        end
    end

    assign q = chain_q[STAGES-1];

endmodule

// File: rtl/toggle_rx.sv
// Toggle-handshake receiver: synchronizes T_in, emits one Pulse per accepted level change,
// enforces a HOLDOFF dead time and flags dropped toggles. Count is built only with TOGGLE_RX_COUNT_EN.
module toggle_rx
    import toggle_rx_pkg::*;
#(
    parameter int SYNC_STAGES = TOGGLE_RX_SYNC_STAGES_DEF,
    parameter int HOLDOFF     = TOGGLE_RX_HOLDOFF_DEF,
    parameter int CNT_W       = TOGGLE_RX_CNT_W_DEF
) (
    input  logic             Clock,
    input  logic             Clear,
    input  logic             T_in,
    output logic             Pulse,
    output logic             Ack_out,
    output logic [CNT_W-1:0] Count,
    output logic             Overrun,
    output logic             Busy
);

    localparam bit         HOLD_EN   = (HOLDOFF > 0);
    localparam logic [3:0] HOLD_LOAD = (HOLDOFF > 0) ? 4'(HOLDOFF - 1) : 4'd0;

    logic       sync_t_s;
    logic       last_t_q;
    logic       detect_s;
    state_e     state_q;
    logic [3:0] hold_q;
    logic       pulse_q;
    logic       ack_q;
    logic       overrun_q;
    logic       busy_q;

    sync_chain #(
        .STAGES(SYNC_STAGES)
    ) u_sync (
        .Clock(Clock),
        .Clear(Clear),
        .d    (T_in),
        .init (T_in),
        .q    (sync_t_s)
    );

    // Previous synchronized level, used for edge detection.
    always_ff @(posedge Clock) begin
        if (Clear) begin
            last_t_q <= T_in;
        end else begin
            last_t_q <= sync_t_s;
        end
    end

    assign detect_s = sync_t_s ^ last_t_q;

    // Control FSM with registered strobe, acknowledge, busy and overrun outputs.
    always_ff @(posedge Clock) begin
        if (Clear) begin
            state_q   <= IDLE;
            hold_q    <= 4'd0;
            pulse_q   <= 1'b0;
            ack_q     <= 1'b0;
            overrun_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            pulse_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (detect_s) begin
                        state_q <= PULSE;
                        pulse_q <= 1'b1;
                        ack_q   <= ~ack_q;
                        busy_q  <= 1'b1;
                    end
                end
                PULSE: begin
                    if (detect_s) begin
                        overrun_q <= 1'b1;
                    end
                    if (HOLD_EN) begin
                        state_q <= HOLD;
                        hold_q  <= HOLD_LOAD;
                        busy_q  <= 1'b1;
                    end else begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                HOLD: begin
                    if (detect_s) begin
                        overrun_q <= 1'b1;
                    end
                    if (hold_q == 4'd0) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        hold_q <= hold_q - 4'd1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    hold_q  <= 4'd0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

`ifdef TOGGLE_RX_COUNT_EN
    logic [CNT_W-1:0] cnt_q;

    // Accepted-toggle counter; advances on the same edge that raises Pulse and wraps naturally.
    always_ff @(posedge Clock) begin
        if (Clear) begin
            cnt_q <= {CNT_W{1'b0}};
        end else if ((state_q == IDLE) && detect_s) begin
            cnt_q <= cnt_q + CNT_W'(1'b1);
        end else begin
            cnt_q <= cnt_q;
        end
    end

    assign Count = cnt_q;
`else
    assign Count = {CNT_W{1'b0}};
`endif

    assign Pulse   = pulse_q;
    assign Ack_out = ack_q;
    assign Overrun = overrun_q;
    assign Busy    = busy_q;

endmodule
